// File: rtl/div_share_ctrl.sv
// Purpose: round-robin arbiter in front of one iterative restoring divider shared by two requesters.
// Latency: request handshake in cycle 0 -> response in cycle A_W+1; zero divisor responds in cycle 1.
// Backpressure: one operation in flight; requester readies stay low until the response is taken.
//
// Ports:
//   clk, rst                     rising-edge clock, asynchronous active-high reset
//   reqN_valid/ready/a/b (N=0,1) request channels: dividend a (A_W bits), divisor b (B_W bits)
//   resp_valid/ready             response handshake
//   resp_id/quot/rem/div0        requester index, quotient, remainder, divide-by-zero flag
module div_share_ctrl #(
    parameter int A_W = 4,
    parameter int B_W = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [A_W-1:0] req0_a,
    input  logic [B_W-1:0] req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [A_W-1:0] req1_a,
    input  logic [B_W-1:0] req1_b,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [A_W-1:0] resp_quot,
    output logic [B_W-1:0] resp_rem,
    output logic           resp_div0
);

    localparam int CNT_W = (A_W > 1) ? $clog2(A_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(A_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic             rr_ptr;
    logic             cur_id;
    logic [B_W-1:0]   op_b;
    logic [B_W-1:0]   prem;
    logic [A_W-1:0]   quot_sr;
    logic [CNT_W-1:0] cnt;

    logic             grant0, grant1, accept, acc_id;
    logic [A_W-1:0]   acc_a;
    logic [B_W-1:0]   acc_b;
    logic [B_W:0]     shifted;
    logic             ge;
    logic [B_W-1:0]   diff, prem_nxt;
    logic [A_W-1:0]   quot_nxt;
    logic             last;

    // With a single valid requester it wins outright; on a tie rr_ptr picks.
    assign grant0 = req0_valid && (!req1_valid || !rr_ptr);
    assign grant1 = req1_valid && (!req0_valid ||  rr_ptr);
    assign accept = (state == IDLE) && (grant0 || grant1);
    assign acc_id = grant1;
    assign acc_a  = grant1 ? req1_a : req0_a;
    assign acc_b  = grant1 ? req1_b : req0_b;

    // The stored remainder is always < b, so it fits in B_W bits; only the
    // shifted trial value needs the extra bit. When ge holds, the true
    // difference is < b, so a B_W-bit modular subtract gives it exactly.
    assign shifted  = {prem, quot_sr[A_W-1]};
    assign ge       = shifted >= {1'b0, op_b};
    assign diff     = shifted[B_W-1:0] - op_b;
    assign prem_nxt = ge ? diff : shifted[B_W-1:0];
    assign quot_nxt = {quot_sr[A_W-2:0], ge};
    assign last     = (cnt == LAST_STEP);

    assign resp_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (accept) begin
                    state_nxt = (acc_b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Returning to IDLE (not accepting here) keeps a new grant
                // out of the response handshake cycle.
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Response fields load only on entry to DONE, so they are frozen while
    // the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= 1'b0;
            cur_id    <= 1'b0;
            op_b      <= '0;
            prem      <= '0;
            quot_sr   <= '0;
            cnt       <= '0;
            resp_id   <= 1'b0;
            resp_quot <= '0;
            resp_rem  <= '0;
            resp_div0 <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr  <= ~acc_id;
                        cur_id  <= acc_id;
                        op_b    <= acc_b;
                        prem    <= '0;
                        quot_sr <= acc_a;
                        cnt     <= '0;
                        if (acc_b == '0) begin
                            resp_id   <= acc_id;
                            resp_quot <= '1;
                            resp_rem  <= '0;
                            resp_div0 <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    prem    <= prem_nxt;
                    quot_sr <= quot_nxt;
                    if (last) begin
                        cnt       <= '0;
                        resp_id   <= cur_id;
                        resp_quot <= quot_nxt;
                        resp_rem  <= prem_nxt;
                        resp_div0 <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl: reset, basic divide, round-robin,
// divide-by-zero, response backpressure, mid-operation reset, full sweep.
module tb_div_share_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a = '0, req1_a = '0;
    logic [1:0] req0_b = '0, req1_b = '0;
    logic       resp_valid;
    logic       resp_ready = 1'b0;
    logic       resp_id;
    logic [3:0] resp_quot;
    logic [1:0] resp_rem;
    logic       resp_div0;

    int n_checks = 0;
    int n_pass   = 0;

    div_share_ctrl #(.A_W(4), .B_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_quot  (resp_quot),
        .resp_rem   (resp_rem),
        .resp_div0  (resp_div0)
    );

    always #5 clk = ~clk;

    // Called at posedge+1 of cycle 1 after a request handshake; returns the
    // cycle index at which resp_valid is first seen (40 means timed out).
    task automatic wait_resp(output int lat);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Presents one request, waits (bounded) for its ready, completes the
    // handshake and withdraws valid. Returns at posedge+1 of cycle 1.
    task automatic issue(input bit id, input logic [3:0] a, input logic [1:0] b,
                         output bit ok, output int waited);
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
        #1;
        waited = 0;
        while ((id ? req1_ready : req0_ready) !== 1'b1 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        ok = ((id ? req1_ready : req0_ready) === 1'b1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({resp_valid, resp_id, resp_quot, resp_rem, resp_div0, req0_ready, req1_ready} !== 11'd0)
            $display("FAIL reset_outputs: got v=%b id=%b q=%h r=%h z=%b rdy=%b%b, want all zero",
                     resp_valid, resp_id, resp_quot, resp_rem, resp_div0, req0_ready, req1_ready);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok; int w; int lat;
        issue(1'b0, 4'd13, 2'd3, ok, w);
        n_checks++;
        if (!ok || w != 0) $display("FAIL basic_accept: ok=%0d waited=%0d, want ok=1 waited=0", ok, w);
        else n_pass++;
        wait_resp(lat);
        n_checks++;
        if (lat != 5) $display("FAIL basic_latency: got %0d, want 5", lat);
        else n_pass++;
        n_checks++;
        if ({resp_quot, resp_rem, resp_id, resp_div0} !== {4'd4, 2'd1, 1'b0, 1'b0})
            $display("FAIL basic_result: got q=%0d r=%0d id=%b z=%b, want q=4 r=1 id=0 z=0",
                     resp_quot, resp_rem, resp_id, resp_div0);
        else n_pass++;
        consume();
        n_checks++;
        if (resp_valid !== 1'b0) $display("FAIL basic_resp_drop: got %b, want 0", resp_valid);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int lat;
        do_reset();
        req0_valid = 1'b1; req0_a = 4'd15; req0_b = 2'd1;
        req1_valid = 1'b1; req1_a = 4'd9;  req1_b = 2'd2;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL rr_first_grant: got rdy0/1=%b%b, want 10", req0_ready, req1_ready);
        else n_pass++;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        n_checks++;
        if (req1_ready !== 1'b0) $display("FAIL rr_calc_ready: got %b, want 0", req1_ready);
        else n_pass++;
        wait_resp(lat);
        n_checks++;
        if (lat != 5 || {resp_quot, resp_rem, resp_id} !== {4'd15, 2'd0, 1'b0})
            $display("FAIL rr_resp0: got lat=%0d q=%0d r=%0d id=%b, want lat=5 q=15 r=0 id=0",
                     lat, resp_quot, resp_rem, resp_id);
        else n_pass++;
        resp_ready = 1'b1;
        #1;
        n_checks++;
        if (req1_ready !== 1'b0) $display("FAIL rr_no_accept_in_resp: got %b, want 0", req1_ready);
        else n_pass++;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++;
        if ({resp_valid, req1_ready} !== 2'b01)
            $display("FAIL rr_second_grant: got valid=%b rdy1=%b, want 0 1", resp_valid, req1_ready);
        else n_pass++;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_resp(lat);
        n_checks++;
        if (lat != 5 || {resp_quot, resp_rem, resp_id, resp_div0} !== {4'd4, 2'd1, 1'b1, 1'b0})
            $display("FAIL rr_resp1: got lat=%0d q=%0d r=%0d id=%b z=%b, want lat=5 q=4 r=1 id=1 z=0",
                     lat, resp_quot, resp_rem, resp_id, resp_div0);
        else n_pass++;
        consume();
        // Last grant was 1, so a tie now goes to 0.
        req0_valid = 1'b1; req0_a = 4'd6; req0_b = 2'd2;
        req1_valid = 1'b1; req1_a = 4'd5; req1_b = 2'd1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b10)
            $display("FAIL rr_tie_to_0: got rdy0/1=%b%b, want 10", req0_ready, req1_ready);
        else n_pass++;
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_resp(lat);
        n_checks++;
        if ({resp_quot, resp_rem, resp_id} !== {4'd3, 2'd0, 1'b0})
            $display("FAIL rr_resp_tie0: got q=%0d r=%0d id=%b, want q=3 r=0 id=0",
                     resp_quot, resp_rem, resp_id);
        else n_pass++;
        consume();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_checks++;
        if ({req0_ready, req1_ready} !== 2'b01)
            $display("FAIL rr_tie_to_1: got rdy0/1=%b%b, want 01", req0_ready, req1_ready);
        else n_pass++;
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_resp(lat);
        n_checks++;
        if ({resp_quot, resp_rem, resp_id} !== {4'd5, 2'd0, 1'b1})
            $display("FAIL rr_resp_tie1: got q=%0d r=%0d id=%b, want q=5 r=0 id=1",
                     resp_quot, resp_rem, resp_id);
        else n_pass++;
        consume();
    endtask

    task automatic test_div_zero();
        bit ok; int w; int lat;
        issue(1'b1, 4'd7, 2'd0, ok, w);
        n_checks++;
        if (!ok || w != 0) $display("FAIL div0_accept: ok=%0d waited=%0d, want ok=1 waited=0", ok, w);
        else n_pass++;
        wait_resp(lat);
        n_checks++;
        if (lat != 1 || {resp_quot, resp_rem, resp_div0, resp_id} !== {4'hF, 2'd0, 1'b1, 1'b1})
            $display("FAIL div0_result: got lat=%0d q=%h r=%0d z=%b id=%b, want lat=1 q=f r=0 z=1 id=1",
                     lat, resp_quot, resp_rem, resp_div0, resp_id);
        else n_pass++;
        consume();
    endtask

    task automatic test_backpressure();
        bit ok; int w; int lat;
        issue(1'b0, 4'd10, 2'd3, ok, w);
        wait_resp(lat);
        n_checks++;
        if (!ok || lat != 5) $display("FAIL bp_setup: ok=%0d lat=%0d, want ok=1 lat=5", ok, lat);
        else n_pass++;
        req0_valid = 1'b1; req0_a = 4'd8; req0_b = 2'd2;
        for (int i = 0; i < 10; i++) begin
            #1;
            n_checks++;
            if ({resp_valid, resp_quot, resp_rem, resp_id, resp_div0, req0_ready, req1_ready}
                    !== {1'b1, 4'd3, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0})
                $display("FAIL bp_hold_%0d: got v=%b q=%0d r=%0d id=%b z=%b rdy=%b%b, want v=1 q=3 r=1 id=0 z=0 rdy=00",
                         i, resp_valid, resp_quot, resp_rem, resp_id, resp_div0, req0_ready, req1_ready);
            else n_pass++;
            @(posedge clk);
        end
        #1;
        resp_ready = 1'b1;
        #1;
        n_checks++;
        if (req0_ready !== 1'b0) $display("FAIL bp_release_cycle_ready: got %b, want 0", req0_ready);
        else n_pass++;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++;
        if ({resp_valid, req0_ready} !== 2'b01)
            $display("FAIL bp_next_accept: got valid=%b rdy0=%b, want 0 1", resp_valid, req0_ready);
        else n_pass++;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_resp(lat);
        n_checks++;
        if (lat != 5 || {resp_quot, resp_rem, resp_id} !== {4'd4, 2'd0, 1'b0})
            $display("FAIL bp_pending_result: got lat=%0d q=%0d r=%0d id=%b, want lat=5 q=4 r=0 id=0",
                     lat, resp_quot, resp_rem, resp_id);
        else n_pass++;
        consume();
    endtask

    task automatic test_mid_reset();
        bit ok; int w; int lat; bit seen;
        issue(1'b0, 4'd12, 2'd2, ok, w);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({resp_valid, resp_id, resp_quot, resp_rem, resp_div0, req0_ready, req1_ready} !== 11'd0)
            $display("FAIL midrst_async: got v=%b id=%b q=%h r=%h z=%b rdy=%b%b, want all zero",
                     resp_valid, resp_id, resp_quot, resp_rem, resp_div0, req0_ready, req1_ready);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) $display("FAIL midrst_no_resp: got a response, want none");
        else n_pass++;
        issue(1'b1, 4'd11, 2'd3, ok, w);
        wait_resp(lat);
        n_checks++;
        if (!ok || lat != 5 || {resp_quot, resp_rem, resp_id} !== {4'd3, 2'd2, 1'b1})
            $display("FAIL midrst_recover: got ok=%0d lat=%0d q=%0d r=%0d id=%b, want ok=1 lat=5 q=3 r=2 id=1",
                     ok, lat, resp_quot, resp_rem, resp_id);
        else n_pass++;
        consume();
    endtask

    task automatic test_sweep();
        bit ok; int w; int lat;
        logic [3:0] a, eq;
        logic [1:0] b, er;
        bit id, ez;
        int elat;
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                a  = 4'(ai);
                b  = 2'(bi);
                id = 1'((ai * 4 + bi) % 2);
                if (bi == 0) begin eq = 4'hF; er = 2'd0; ez = 1'b1; elat = 1; end
                else begin eq = 4'(ai / bi); er = 2'(ai % bi); ez = 1'b0; elat = 5; end
                issue(id, a, b, ok, w);
                wait_resp(lat);
                n_checks++;
                if (!ok || lat != elat || {resp_quot, resp_rem, resp_div0, resp_id} !== {eq, er, ez, id})
                    $display("FAIL sweep_%0d_%0d: got ok=%0d lat=%0d q=%0d r=%0d z=%b id=%b, want lat=%0d q=%0d r=%0d z=%b id=%b",
                             ai, bi, ok, lat, resp_quot, resp_rem, resp_div0, resp_id, elat, eq, er, ez, id);
                else n_pass++;
                if (resp_valid === 1'b1) consume();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_div_zero();
        test_backpressure();
        test_mid_reset();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
